// File: rtl/ic_refill_ctrl_if.sv
// Refill controller bundle: cache-side request/line return plus the AXI AR and R channels.
// master = refill controller (AXI master, line producer); slave = cache/interconnect side.
interface ic_refill_ctrl_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 8
);
  logic                    req;
  logic [ADDR_W-1:0]       addr;
  logic                    cancel;
  logic                    busy;
  logic                    line_valid;
  logic [32*LINE_WORDS-1:0] line_data;
  logic                    line_err;

  logic [3:0]              arid;
  logic [ADDR_W-1:0]       araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    input  req, addr, cancel, arready, rdata, rresp, rlast, rvalid,
    output busy, line_valid, line_data, line_err,
           arid, araddr, arlen, arsize, arburst, arvalid, rready
  );

  modport slave (
    output req, addr, cancel, arready, rdata, rresp, rlast, rvalid,
    input  busy, line_valid, line_data, line_err,
           arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/ic_refill_ctrl.sv
// ICache line refill: one AXI4 INCR burst per miss, beats packed into a line; line_valid 2+LINE_WORDS cycles after req
// when AR/R never stall. AR held until arready; a cancel drains the remaining beats instead of dropping the handshake.
module ic_refill_ctrl #(
  parameter int         ADDR_W     = 32,
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] ARID       = 4'd0
) (
  input  logic             clk,
  input  logic             rst,
  ic_refill_ctrl_if.master bus
);

  localparam int OFS_W = $clog2(4*LINE_WORDS);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_araddr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_cxl;
  logic [31:0]       r_word [LINE_WORDS];

  logic              w_req_acc;
  logic              w_beat;
  logic              w_arvalid;
  logic              w_rready;
  logic              w_busy;
  logic              w_line_valid;
  logic [32*LINE_WORDS-1:0] w_line;
  logic              w_addr_unused;

  assign w_req_acc     = bus.req && !bus.cancel;
  assign w_beat        = bus.rvalid && w_rready;
  assign w_addr_unused = ^bus.addr[OFS_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_acc) w_next = S_ADDR;
      end
      S_ADDR: begin
        if (bus.arready) w_next = (bus.cancel || r_cxl) ? S_DRAIN : S_DATA;
      end
      S_DATA: begin
        // A cancel on the final beat has nothing left to drain.
        if (w_beat && bus.rlast) w_next = bus.cancel ? S_IDLE : S_DONE;
        else if (bus.cancel)     w_next = S_DRAIN;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      S_DRAIN: begin
        if (w_beat && bus.rlast) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    w_busy       = 1'b1;
    w_line_valid = 1'b0;
    case (r_state)
      S_IDLE:          w_busy       = 1'b0;
      S_ADDR:          w_arvalid    = 1'b1;
      S_DATA, S_DRAIN: w_rready     = 1'b1;
      S_DONE:          w_line_valid = 1'b1;
      default:         w_busy       = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_araddr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_cxl    <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) r_word[i] <= '0;
    end else begin
      if (r_state == S_IDLE && w_req_acc) begin
        r_araddr <= {bus.addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        r_cnt    <= '0;
        r_err    <= 1'b0;
        r_cxl    <= 1'b0;
      end
      if (r_state == S_ADDR && bus.cancel) r_cxl <= 1'b1;
      if (r_state == S_DATA && w_beat) begin
        r_err <= r_err | (bus.rresp != 2'b00);
        // Counter parks at LINE_WORDS so overlong bursts cannot wrap onto word 0.
        if (r_cnt != CNT_W'(LINE_WORDS)) begin
          r_cnt                     <= r_cnt + CNT_W'(1);
          r_word[r_cnt[IDX_W-1:0]]  <= bus.rdata;
        end
      end
    end
  end

  always_comb begin
    w_line = '0;
    for (int i = 0; i < LINE_WORDS; i++) w_line[32*i +: 32] = r_word[i];
  end

  assign bus.busy       = w_busy;
  assign bus.line_valid = w_line_valid;
  assign bus.line_data  = w_line;
  assign bus.line_err   = r_err;
  assign bus.arid       = ARID;
  assign bus.araddr     = r_araddr;
  assign bus.arlen      = 8'(LINE_WORDS - 1);
  assign bus.arsize     = 3'b010;
  assign bus.arburst    = 2'b01;
  assign bus.arvalid    = w_arvalid;
  assign bus.rready     = w_rready;

endmodule
